// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver for common-anode displays.
// Inputs are captured once per scan frame, so a frame never mixes old and new digits.
module sseg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  input  logic                    blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    shadow_lz_q, shadow_lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    slot_end, frame_end;
  logic                    lead_blank;
  logic                    dark;
  logic [3:0]              nibble;

  function automatic logic [6:0] hex_segs(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are zero.
  function automatic logic digit_suppressed(input logic [4*NUM_DIGITS-1:0] v,
                                            input logic                    lz,
                                            input logic [IDX_W-1:0]        k);
    logic any_nz;
    any_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) any_nz = 1'b1;
    end
    return lz && (k != '0) && !any_nz;
  endfunction

  if (BLANK_CYCLES == 0) begin : g_no_lead
    assign lead_blank = 1'b0;
  end else begin : g_lead
    assign lead_blank = (cnt_d < CNT_W'(BLANK_CYCLES));
  end

  always_comb begin
    slot_end       = (cnt_q == CNT_LAST);
    frame_end      = slot_end && (idx_q == IDX_LAST);
    cnt_d          = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    shadow_value_d = shadow_value_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_lz_d    = shadow_lz_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    if (frame_end) begin
      shadow_value_d = value;
      shadow_dp_d    = dp_in;
      shadow_lz_d    = lz_suppress;
    end

    // Outputs are computed from next state so the registered drive matches the held cnt/idx.
    nibble       = shadow_value_d[{idx_d, 2'b00} +: 4];
    dark         = blank_in || lead_blank || digit_suppressed(shadow_value_d, shadow_lz_d, idx_d);
    an_d         = dark ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    segs_d       = dark ? 7'h7F : hex_segs(nibble);
    dp_d         = dark ? 1'b1 : ~shadow_dp_d[idx_d];
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_lz_q    <= 1'b0;
      an_q           <= '1;
      segs_q         <= 7'h7F;
      dp_q           <= 1'b1;
      frame_tick_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_lz_q    <= shadow_lz_d;
      an_q           <= an_d;
      segs_q         <= segs_d;
      dp_q           <= dp_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign segs       = segs_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule
